// File: rtl/debug_serial_pkg.sv
// Shared constants and sequencer state encoding for the serial debug link.
package debug_serial_pkg;

  localparam int         NUM_DEBUG_PORTS     = 7;
  localparam int         UART_BITS_PER_FRAME = 10;
  localparam logic [7:0] DEFAULT_SYNC_BYTE   = 8'hA5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_SYNC = 2'd1,
    SEND_DATA = 2'd2,
    SEND_CSUM = 2'd3
  } seqState_t;

endpackage

// File: rtl/debug_serial_tx_uart.sv
// UART 8N1 byte shifter: start bit, 8 data bits LSB first, stop bit.
// A new byte may be started on the byte_done cycle so frames abut with no gap.
module uart_tx_byte
  import debug_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] byte_in,
  input  logic       start,
  output logic       tx,
  output logic       byte_done
);

  localparam int              BW            = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST     = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_BIT      = 4'(UART_BITS_PER_FRAME - 1);
  localparam logic [3:0]      LAST_DATA_BIT = 4'(UART_BITS_PER_FRAME - 2);

  logic          active;
  logic [BW-1:0] baudCnt;
  logic [3:0]    bitCnt;
  logic [7:0]    shiftReg;

  // Last cycle of the stop bit.
  assign byte_done = active && (bitCnt == LAST_BIT) && (baudCnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      active   <= 1'b0;
      tx       <= 1'b1;
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
    end else if (start && (!active || byte_done)) begin
      active   <= 1'b1;
      tx       <= 1'b0;
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= byte_in;
    end else if (active) begin
      if (baudCnt == BAUD_LAST) begin
        baudCnt <= '0;
        if (bitCnt == LAST_BIT) begin
          active <= 1'b0;
          tx     <= 1'b1;
          bitCnt <= '0;
        end else begin
          bitCnt   <= bitCnt + 4'd1;
          tx       <= (bitCnt == LAST_DATA_BIT) ? 1'b1 : shiftReg[0];
          shiftReg <= {1'b0, shiftReg[7:1]};
        end
      end else begin
        baudCnt <= baudCnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/debug_serial_tx.sv
// Debug link transmitter: snapshots seven CPU debug bytes and sends a framed
// packet. Define DEBUG_SERIAL_TX_CHECKSUM_EN to append an XOR checksum byte.
module debug_serial_tx
  import debug_serial_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  input  logic       send_req,
  output logic       tx,
  output logic       busy,
  output logic       pkt_done
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DEBUG_PORTS - 1);

  logic [NUM_DEBUG_PORTS-1:0][7:0] portsIn;
  logic [NUM_DEBUG_PORTS-1:0][7:0] snapshot;
  seqState_t  state;
  logic [2:0] dataIdx;
  logic [2:0] nextIdx;
  logic       byteDone;
  logic       byteStart;
  logic [7:0] byteSel;

  assign portsIn = {debug_port7, debug_port6, debug_port5, debug_port4,
                    debug_port3, debug_port2, debug_port1};
  assign nextIdx = dataIdx + 3'd1;

`ifdef DEBUG_SERIAL_TX_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < NUM_DEBUG_PORTS; i++) csum = csum ^ snapshot[i];
  end
`endif

  // Next byte is handed to the shifter on the byte_done cycle so frames abut.
  always_comb begin
    byteStart = 1'b0;
    byteSel   = SYNC_BYTE;
    case (state)
      IDLE: begin
        byteStart = send_req;
        byteSel   = SYNC_BYTE;
      end
      SEND_SYNC: begin
        byteStart = byteDone;
        byteSel   = snapshot[0];
      end
      SEND_DATA: begin
        if (dataIdx == LAST_IDX) begin
`ifdef DEBUG_SERIAL_TX_CHECKSUM_EN
          byteStart = byteDone;
          byteSel   = csum;
`endif
        end else begin
          byteStart = byteDone;
          byteSel   = snapshot[nextIdx];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state    <= IDLE;
      dataIdx  <= '0;
      snapshot <= '0;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (send_req) begin
            snapshot <= portsIn;
            busy     <= 1'b1;
            state    <= SEND_SYNC;
          end
        end
        SEND_SYNC: begin
          if (byteDone) begin
            state   <= SEND_DATA;
            dataIdx <= '0;
          end
        end
        SEND_DATA: begin
          if (byteDone) begin
            if (dataIdx == LAST_IDX) begin
`ifdef DEBUG_SERIAL_TX_CHECKSUM_EN
              state <= SEND_CSUM;
`else
              state    <= IDLE;
              busy     <= 1'b0;
              pkt_done <= 1'b1;
`endif
            end else begin
              dataIdx <= nextIdx;
            end
          end
        end
`ifdef DEBUG_SERIAL_TX_CHECKSUM_EN
        SEND_CSUM: begin
          if (byteDone) begin
            state    <= IDLE;
            busy     <= 1'b0;
            pkt_done <= 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTxByte (
    .clk      (clk),
    .nreset   (nreset),
    .byte_in  (byteSel),
    .start    (byteStart),
    .tx       (tx),
    .byte_done(byteDone)
  );

endmodule

// File: tb/tb_debug_serial_tx.sv
// Directed bench for debug_serial_tx at CLKS_PER_BIT=4; decodes tx cycle by cycle.
module tb_debug_serial_tx;

  localparam int CPB = 4;
`ifdef DEBUG_SERIAL_TX_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic            send_req = 1'b0;
  logic [6:0][7:0] ports = '0;
  logic            tx;
  logic            busy;
  logic            pkt_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debug_serial_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .debug_port1(ports[0]),
    .debug_port2(ports[1]),
    .debug_port3(ports[2]),
    .debug_port4(ports[3]),
    .debug_port5(ports[4]),
    .debug_port6(ports[5]),
    .debug_port7(ports[6]),
    .send_req   (send_req),
    .tx         (tx),
    .busy       (busy),
    .pkt_done   (pkt_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called on the start-bit cycle of the sync byte; returns on the pkt_done cycle.
  task automatic recv_packet(input logic [8:0][7:0] exp, input int disturbAt, input string name);
    logic [9:0] frame;
    int incons, doneSeen, busyLow, cyc;
    doneSeen = 0;
    busyLow  = 0;
    for (int b = 0; b < NB; b++) begin
      incons = 0;
      frame  = '0;
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < CPB; c++) begin
          cyc = b * 10 * CPB + i * CPB + c;
          if (c == 0) frame[i] = tx;
          else if (tx !== frame[i]) incons++;
          if (pkt_done !== 1'b0) doneSeen++;
          if (busy !== 1'b1) busyLow++;
          if (disturbAt >= 0 && cyc == disturbAt) begin
            ports    = {7{8'hFF}};
            send_req = 1'b1;
          end
          if (disturbAt >= 0 && cyc == disturbAt + 1) send_req = 1'b0;
          tick();
        end
      end
      total++;
      if (frame !== {1'b1, exp[b], 1'b0} || incons != 0) begin
        bad++;
        $display("FAIL %s byte%0d frame got %b want %b unstable_cycles=%0d",
                 name, b, frame, {1'b1, exp[b], 1'b0}, incons);
      end
    end
    total++;
    if (doneSeen != 0 || busyLow != 0) begin
      bad++;
      $display("FAIL %s in-flight pkt_done_cycles=%0d busy_low_cycles=%0d want 0/0",
               name, doneSeen, busyLow);
    end
    total++;
    if ({pkt_done, busy, tx} !== 3'b101) begin
      bad++;
      $display("FAIL %s end pkt_done/busy/tx got %b want 101", name, {pkt_done, busy, tx});
    end
  endtask

  task automatic watch_idle(input int n, input string name);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      if ({pkt_done, busy, tx} !== 3'b001) errs++;
      tick();
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s idle got %0d non-idle cycles want 0", name, errs);
    end
  endtask

  task automatic start_packet(input string name);
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    total++;
    if ({busy, tx} !== 2'b10) begin
      bad++;
      $display("FAIL %s accept busy/tx got %b want 10", name, {busy, tx});
    end
  endtask

  task automatic test_reset;
    nreset   = 1'b0;
    send_req = 1'b0;
    repeat (3) tick();
    total++;
    if ({pkt_done, busy, tx} !== 3'b001) begin
      bad++;
      $display("FAIL reset_hold got %b want 001", {pkt_done, busy, tx});
    end
    nreset = 1'b1;
    tick();
    total++;
    if ({pkt_done, busy, tx} !== 3'b001) begin
      bad++;
      $display("FAIL reset_release got %b want 001", {pkt_done, busy, tx});
    end
    watch_idle(50, "reset_idle");
  endtask

  task automatic test_single;
    ports = {8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    start_packet("single");
    recv_packet({8'h00, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hA5}, -1, "single");
    tick();
    watch_idle(10, "single_after");
  endtask

  task automatic test_checksum;
    ports = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    start_packet("csum");
    recv_packet({8'h00, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hA5}, -1, "csum");
    tick();
    watch_idle(10, "csum_after");
  endtask

  task automatic test_snapshot_ignore;
    ports = {8'hC3, 8'h7E, 8'h81, 8'hF0, 8'h0F, 8'h3C, 8'h5A};
    start_packet("snap");
    recv_packet({8'hA5, 8'hC3, 8'h7E, 8'h81, 8'hF0, 8'h0F, 8'h3C, 8'h5A, 8'hA5}, 150, "snap");
    tick();
    watch_idle(60, "snap_no_second");
  endtask

  task automatic test_back_to_back;
    ports    = {8'hC3, 8'h7E, 8'h81, 8'hF0, 8'h0F, 8'h3C, 8'h5A};
    send_req = 1'b1;
    tick();
    ports = {8'h03, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    recv_packet({8'hA5, 8'hC3, 8'h7E, 8'h81, 8'hF0, 8'h0F, 8'h3C, 8'h5A, 8'hA5}, -1, "b2b_1");
    tick();
    send_req = 1'b0;
    total++;
    if ({pkt_done, busy, tx} !== 3'b010) begin
      bad++;
      $display("FAIL b2b_restart pkt_done/busy/tx got %b want 010", {pkt_done, busy, tx});
    end
    recv_packet({8'hFF, 8'h03, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hA5}, -1, "b2b_2");
    tick();
    watch_idle(20, "b2b_after");
  endtask

  task automatic test_reset_mid;
    ports = {8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    start_packet("rstmid");
    // Cycle 97: byte 2 (debug_port2=02), frame bit 4 = data bit 3 = 0.
    repeat (97) tick();
    total++;
    if (tx !== 1'b0) begin
      bad++;
      $display("FAIL rstmid pre tx got %b want 0", tx);
    end
    nreset = 1'b0;
    tick();
    total++;
    if ({pkt_done, busy, tx} !== 3'b001) begin
      bad++;
      $display("FAIL rstmid abort got %b want 001", {pkt_done, busy, tx});
    end
    nreset = 1'b1;
    tick();
    watch_idle(45, "rstmid_no_resume");
    ports = {8'h03, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    start_packet("rstmid_new");
    recv_packet({8'hFF, 8'h03, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hA5}, -1, "rstmid_new");
    tick();
    watch_idle(10, "rstmid_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_checksum();
    test_snapshot_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_serial_tx.md
Name: debug_serial_tx

Overview:
- Transmit end of the serial debug link.
- The CPU drives seven 8-bit debug bytes (debug_port1..debug_port7). This block snapshots them on request and serialises one framed packet over a UART 8N1 line to the host-side debugger.
- Sits at the top level, between the cpu debug ports and the board TX pin.
- Packet: sync byte, then debug_port1..debug_port7 in order, then an optional checksum byte.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal values are 2 or more.
- SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- nreset  input  1  reset; synchronous, active-low.
- debug_port1..debug_port7  input  8 each  debug bytes from the cpu.
- send_req  input  1  level or pulse; requests one packet.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a packet is in flight.
- pkt_done  output  1  one-cycle pulse at packet end.

Behaviour:
- Reset: nreset low at a clk edge forces tx=1, busy=0, pkt_done=0, sequencer to IDLE, bit/baud counters to 0 and the snapshot to 0.
- Reset mid-packet aborts immediately: tx is high from the next edge and no partial packet resumes.
- Accept: send_req is sampled at an edge where busy=0.
  - On that edge all seven debug bytes are captured into a snapshot register.
  - busy goes 1 and the start bit of the sync byte drives tx from the next cycle (latency 1).
  - send_req while busy=1 is ignored, not queued.
- Packet sequencer states:
  - IDLE -> SEND_SYNC -> SEND_DATA (index 0..6) -> [SEND_CSUM] -> IDLE.
  - The index is 3 bits and advances on each byte-done; leaving SEND_DATA happens when index==6 completes.
- Byte framing:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - No idle gap between bytes: the next start bit follows the stop bit directly.
- Packet duration: 10*CLKS_PER_BIT*N cycles, where N=8 without checksum and 9 with checksum.
- Completion:
  - The cycle after the last stop bit ends, pkt_done=1 for one cycle, busy=0 and tx=1.
  - send_req high in that same cycle is accepted at that edge (back-to-back packets). tx then spends that single cycle high before the next start bit.
- Snapshot stability: changes on debug_port inputs during a packet do not affect the bytes in flight.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; a wrap advances the bit counter (0..9).
- Counter widths: $clog2(CLKS_PER_BIT) bits and 4 bits.

Optional Feature:
- Macro: DEBUG_SERIAL_TX_CHECKSUM_EN.
- Defined: a ninth byte follows debug_port7, equal to the XOR of the seven snapshot data bytes. SYNC_BYTE is excluded from the XOR. N=9.
- Undefined: the checksum state and XOR logic are absent; the packet ends after debug_port7. N=8.

Decomposition:
- Shared package debug_serial_pkg holds:
  - the constants NUM_DEBUG_PORTS=7, UART_BITS_PER_FRAME=10 and DEFAULT_SYNC_BYTE=8'hA5;
  - the sequencer state encoding (IDLE, SEND_SYNC, SEND_DATA, SEND_CSUM).
- One sub-module, uart_tx_byte. It has ports clk, nreset, byte_in[7:0], start, tx, byte_done, and contains the baud counter, bit counter and shift register.
- debug_serial_tx contains the snapshot, packet sequencer and checksum.

Test Plan (CLKS_PER_BIT=4):
- Reset idle: hold nreset=0 for 3 cycles, then release -> tx=1, busy=0, pkt_done=0, and tx stays 1 for 50 cycles with send_req=0.
- Single packet, checksum off: ports=8'h01..8'h07, one-cycle send_req -> busy=1 next cycle. Decoded bytes are A5,01,02,03,04,05,06,07. Each bit is 4 cycles, LSB first. pkt_done pulses exactly 320 cycles after the accept edge+1.
- Checksum on: ports=11,22,33,44,55,66,77 -> 9 bytes, the last = 8'h00 (XOR of the seven data bytes). Duration 360 cycles.
- Snapshot/ignore: change all ports to FF mid-packet and pulse send_req while busy -> the packet still carries the original bytes. Exactly one pkt_done; no second packet.
- Back-to-back: hold send_req=1 continuously -> consecutive packets with a single tx-high cycle between the last stop bit and the next start bit. pkt_done pulses once per packet.
- Reset mid-operation: assert nreset=0 during data bit 3 of debug_port2 -> tx=1 and busy=0 at the next edge. After release, a new send_req produces a complete, correct packet starting with A5.
